// File: rtl/ltsm_sb_hs_tx.sv
// Transmit-side sideband request/response handshake for single-exchange LTSM states.
// Build macro LTSM_SB_HS_TIMEOUT_EN adds the resend timer, retry limit and TIMEOUT state.
module ltsm_sb_hs_tx #(
  parameter int SB_MSG_WIDTH  = 4,
  parameter int REQ_MSG       = 15,
  parameter int RESP_MSG      = 14,
  parameter int RESEND_CYCLES = 1024,
  parameter int MAX_RESENDS   = 3
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_en,
  input  logic                    i_rx_msg_valid,
  input  logic [SB_MSG_WIDTH-1:0] i_decoded_sb_msg,
  input  logic                    i_falling_edge_busy,
  input  logic                    i_rx_valid,
  output logic [SB_MSG_WIDTH-1:0] o_encoded_sb_msg_tx,
  output logic                    o_valid_tx,
  output logic                    o_done,
  output logic                    o_timeout
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_RX  = 3'd1,
    ST_SEND_REQ = 3'd2,
    ST_DONE     = 3'd3,
    ST_TIMEOUT  = 3'd4
  } state_t;

  localparam logic [SB_MSG_WIDTH-1:0] L_REQ  = SB_MSG_WIDTH'(REQ_MSG);
  localparam logic [SB_MSG_WIDTH-1:0] L_RESP = SB_MSG_WIDTH'(RESP_MSG);

  if (RESEND_CYCLES < 1 || MAX_RESENDS < 0) begin : g_bad_cfg
    $error("ltsm_sb_hs_tx: RESEND_CYCLES must be >= 1 and MAX_RESENDS >= 0");
  end

  state_t                  r_cs;
  logic [SB_MSG_WIDTH-1:0] r_code;
  logic                    r_valid_tx;
  logic                    r_done;

  logic w_req_rx;
  logic w_resp_rx;
  logic w_busy_clr;
  logic w_rx_sent;

  assign w_req_rx   = i_rx_msg_valid && (i_decoded_sb_msg == L_REQ);
  assign w_resp_rx  = i_rx_msg_valid && (i_decoded_sb_msg == L_RESP);
  assign w_busy_clr = i_falling_edge_busy && !i_rx_valid;
  assign w_rx_sent  = i_falling_edge_busy && i_rx_valid;

`ifdef LTSM_SB_HS_TIMEOUT_EN
  localparam int RCW = (RESEND_CYCLES > 1) ? $clog2(RESEND_CYCLES) : 1;
  localparam int RTW = (MAX_RESENDS > 0) ? $clog2(MAX_RESENDS + 1) : 1;
  localparam logic [RCW-1:0] L_RC_LAST = RCW'(RESEND_CYCLES - 1);
  localparam logic [RTW-1:0] L_MAX_RT  = RTW'(MAX_RESENDS);

  logic [RCW-1:0] r_resend_cnt;
  logic [RTW-1:0] r_retry_cnt;
  logic           r_timeout;
`endif

  // o_valid_tx/o_encoded_sb_msg_tx: the message is offered while o_valid_tx is high and is
  // consumed when the sideband reports the end of a TX-owned transfer (busy falling edge with
  // !i_rx_valid). A send event in the same cycle re-arms valid, overriding that clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cs         <= ST_IDLE;
      r_code       <= '0;
      r_valid_tx   <= 1'b0;
      r_done       <= 1'b0;
`ifdef LTSM_SB_HS_TIMEOUT_EN
      r_resend_cnt <= '0;
      r_retry_cnt  <= '0;
      r_timeout    <= 1'b0;
`endif
    end else begin
      if (w_busy_clr) r_valid_tx <= 1'b0;

      case (r_cs)
        ST_IDLE: begin
          r_code <= '0;
          r_done <= 1'b0;
`ifdef LTSM_SB_HS_TIMEOUT_EN
          r_resend_cnt <= '0;
          r_retry_cnt  <= '0;
          r_timeout    <= 1'b0;
`endif
          if (i_en) begin
            if (w_req_rx) begin
              r_cs <= ST_WAIT_RX;
            end else begin
              r_cs       <= ST_SEND_REQ;
              r_code     <= L_REQ;
              r_valid_tx <= 1'b1;
            end
          end
        end

        ST_WAIT_RX: begin
          if (!i_en) begin
            r_cs <= ST_IDLE;
          end else if (w_rx_sent) begin
            r_cs       <= ST_SEND_REQ;
            r_code     <= L_REQ;
            r_valid_tx <= 1'b1;
          end
        end

        ST_SEND_REQ: begin
          if (!i_en) begin
            r_cs <= ST_IDLE;
          end else if (w_resp_rx) begin
            r_cs   <= ST_DONE;
            r_done <= 1'b1;
          end
`ifdef LTSM_SB_HS_TIMEOUT_EN
          else if (r_resend_cnt == L_RC_LAST) begin
            if (r_retry_cnt < L_MAX_RT) begin
              r_code       <= L_REQ;
              r_valid_tx   <= 1'b1;
              r_resend_cnt <= '0;
              r_retry_cnt  <= r_retry_cnt + 1'b1;
            end else begin
              r_cs      <= ST_TIMEOUT;
              r_timeout <= 1'b1;
            end
          end else begin
            r_resend_cnt <= r_resend_cnt + 1'b1;
          end
`endif
        end

        ST_DONE, ST_TIMEOUT: begin
          if (!i_en) r_cs <= ST_IDLE;
        end

        default: r_cs <= ST_IDLE;
      endcase
    end
  end

  assign o_encoded_sb_msg_tx = r_code;
  assign o_valid_tx          = r_valid_tx;
  assign o_done              = r_done;
`ifdef LTSM_SB_HS_TIMEOUT_EN
  assign o_timeout = r_timeout;
`else
  assign o_timeout = 1'b0;
`endif

endmodule

// File: doc/ltsm_sb_hs_tx.md
# ltsm_sb_hs_tx

Parametrised transmit-side sideband handshake engine for LTSM states that use a single request/response exchange (TRAINERROR, PHYRETRAIN entry, L1/L2 entry and similar). It sends `REQ_MSG` to the partner and waits for `RESP_MSG`. If the partner's request arrives first, it defers to the local RX handshake. A bounded resend/timeout mechanism is added. It sits between the LTSM top FSM and the sideband encoder/arbiter, alongside a matching RX handshake block.

## Interface
Parameters:
- `SB_MSG_WIDTH`, 4, width of encoded/decoded sideband message codes.
- `REQ_MSG`, 15, code sent as the request.
- `RESP_MSG`, 14, code expected as the partner's response.
- `RESEND_CYCLES`, 1024, cycles in `SEND_REQ` without a response before the request is resent.
- `MAX_RESENDS`, 3, resends allowed before `TIMEOUT`.

Ports (reset `i_rst_n`, asynchronous, active-low; clock `i_clk`):
- `i_clk`  in  1  clock.
- `i_rst_n`  in  1  async active-low reset.
- `i_en`  in  1  level enable from LTSM; deassertion aborts to `IDLE`.
- `i_rx_msg_valid`  in  1  `i_decoded_sb_msg` is valid this cycle.
- `i_decoded_sb_msg`  in  `SB_MSG_WIDTH`  decoded partner message.
- `i_falling_edge_busy`  in  1  one-cycle pulse: sideband finished transmitting the current message.
- `i_rx_valid`  in  1  local RX handshake block currently owns the sideband.
- `o_encoded_sb_msg_tx`  out  `SB_MSG_WIDTH`  message code to encoder.
- `o_valid_tx`  out  1  TX has a message pending for the sideband.
- `o_done`  out  1  handshake completed; held while `i_en`.
- `o_timeout`  out  1  resends exhausted; held while `i_en`.

## Operation
- States: `IDLE`, `WAIT_RX`, `SEND_REQ`, `DONE`, `TIMEOUT` (3-bit encoding).
- `IDLE`:
  - If `i_en` and not (`i_rx_msg_valid` and msg==`REQ_MSG`), go to `SEND_REQ`.
  - If `i_en` and `i_rx_msg_valid` and msg==`REQ_MSG`, go to `WAIT_RX`.
  - Otherwise stay in `IDLE`.
- `WAIT_RX`: when `i_falling_edge_busy` and `i_rx_valid` (RX response sent), go to `SEND_REQ`.
- `SEND_REQ`:
  - `i_rx_msg_valid` and msg==`RESP_MSG` goes to `DONE`. This has priority over resend/timeout in the same cycle.
  - Otherwise `resend_cnt` increments each cycle.
  - At `resend_cnt==RESEND_CYCLES-1`: if `retry_cnt<MAX_RESENDS`, issue a resend, clear `resend_cnt` and increment `retry_cnt`. Else go to `TIMEOUT`.
- `DONE` and `TIMEOUT` are terminal until `i_en` deasserts.
- In every non-`IDLE` state, `!i_en` goes to `IDLE` next cycle. This has the highest priority.
- Send event: the transition into `SEND_REQ`, or a resend. On a send event, `o_encoded_sb_msg_tx<=REQ_MSG` and `o_valid_tx<=1`.
- `o_valid_tx` clears on `i_falling_edge_busy && !i_rx_valid`. Set wins over clear in the same cycle.
- In `IDLE`, `o_encoded_sb_msg_tx`, `o_done`, `o_timeout` and both counters are 0. `o_valid_tx` is not forced low in `IDLE`; it clears only through the busy-falling-edge rule.
- Counter widths: `resend_cnt` is `$clog2(RESEND_CYCLES)`; `retry_cnt` is `$clog2(MAX_RESENDS+1)`. Neither counter wraps: it resets to 0 rather than overflowing.

## Timing
- Reset: `CS=IDLE`; all outputs 0; counters 0.
- Outputs are registered. A send event decided in cycle N is visible on `o_valid_tx` and `o_encoded_sb_msg_tx` at N+1.
- `o_done` and `o_timeout` rise one cycle after the terminal transition decision, i.e. the same edge `CS` enters the state. They fall one cycle after `CS` returns to `IDLE`.
- A `RESP_MSG` accepted in the same cycle as the `IDLE`→`SEND_REQ` decision is ignored. It is only valid in `SEND_REQ`.
- Reset mid-handshake clears everything immediately (asynchronous); no message is re-driven.

## Configuration
- `LTSM_SB_HS_TIMEOUT_EN`:
  - When defined: the resend/timeout counters and the `TIMEOUT` state are built.
  - When undefined: `SEND_REQ` waits indefinitely for `RESP_MSG`, no resend occurs, and `o_timeout` is tied to 0.
  - Parameters `RESEND_CYCLES`/`MAX_RESENDS` are accepted but unused when undefined.

## Test plan
- Local-initiated: `i_en`=1 with no partner message → `o_valid_tx`=1, code 15 at +1 cycle. Busy pulse with `i_rx_valid`=0 → `o_valid_tx`=0. `RESP_MSG` 14 with `i_rx_msg_valid` → `o_done`=1 next cycle.
- Partner-first: `i_en`=1 with `REQ_MSG` 15 valid → `WAIT_RX`, `o_valid_tx` stays 0. Busy pulse with `i_rx_valid`=1 → code 15 sent. Response 14 → `o_done`.
- Resend: `RESEND_CYCLES`=8, `MAX_RESENDS`=2, no response → request re-issued at 8 and 16 cycles after entry. `o_timeout`=1 at 24 cycles (`LTSM_SB_HS_TIMEOUT_EN` defined).
- Simultaneous events: response 14 arrives in the same cycle `resend_cnt` hits its limit → `DONE`, no resend, `o_timeout` stays 0.
- Abort: drop `i_en` in `SEND_REQ` and in `DONE` → `IDLE` next cycle; `o_done`, code and counters return to 0.
- Macro undefined: 100 000 cycles without a response → no resend, `o_timeout`=0; a later response 14 still yields `o_done`.
